// File: rtl/elevator_controller_if.sv
// Purpose: signal bundle between the elevator scheduler and its environment.
//   The scalar clock and reset are not part of this bundle.
// Signals:
//   floorReq   requester -> controller  NUM_FLOORS  request pulses/levels, bit i = floor i
//   currentFl  controller -> requester  3           car floor index, feeds displayFloor
//   moving     controller -> requester  1           car is travelling between floors
//   dirUp      controller -> requester  1           current/preferred direction, 1 = up
//   doorOpen   controller -> requester  1           door is open at currentFl
//   pending    controller -> requester  NUM_FLOORS  latched, not yet served requests
//   state_dbg  controller -> requester  2           scheduler state (0 idle, 1 move, 2 door)
// Handshake: there is no valid/ready pair on this bundle. floorReq is sampled
//   on every rising clock edge and is never back-pressured; a request held for
//   several cycles is simply latched again. Every status signal is a registered
//   value that is valid on every cycle.
interface elevator_controller_if #(
   parameter int NUM_FLOORS = 7
);
   logic [NUM_FLOORS-1:0] floorReq;
   logic [2:0]            currentFl;
   logic                  moving;
   logic                  dirUp;
   logic                  doorOpen;
   logic [NUM_FLOORS-1:0] pending;
   logic [1:0]            state_dbg;

   // master: the side that issues floor requests (hall/car panels, bench)
   modport master (
      output floorReq,
      input  currentFl, moving, dirUp, doorOpen, pending, state_dbg
   );

   // slave: the scheduler itself
   modport slave (
      input  floorReq,
      output currentFl, moving, dirUp, doorOpen, pending, state_dbg
   );
endinterface

// File: rtl/elevator_controller.sv
// Purpose: SCAN-style scheduler for the elevator car. Latches floor requests,
//   keeps travelling in one direction while requests remain ahead, times each
//   one-floor move and the door dwell with one shared down-counter, and reports
//   the car floor for the floor display.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high; returns car to floor 0, idle, up
//   bus    elevator_controller_if.slave: floorReq in; currentFl, moving,
//          dirUp, doorOpen, pending, state_dbg out (all registered)
module elevator_controller #(
   parameter int NUM_FLOORS    = 7,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   elevator_controller_if.slave bus
);

   localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
   localparam logic [2:0]    TOP_FLOOR   = 3'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            cur_fl_q, cur_fl_d;
   logic                  dir_up_q, dir_up_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;

   logic [NUM_FLOORS-1:0] req_all;
   logic [NUM_FLOORS-1:0] clr;
   logic [NUM_FLOORS-1:0] above_mask, below_mask;
   logic [NUM_FLOORS-1:0] cur_bit, next_bit;
   logic                  any_above, any_below, here_req;
   logic                  arrive_req, door_req;
   logic [2:0]            next_fl;

   // One-hot of a floor index; built with a loop so an index beyond
   // NUM_FLOORS-1 simply selects nothing.
   function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [2:0] fl);
      logic [NUM_FLOORS-1:0] b;
      b = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         b[i] = (fl == 3'(i));
      end
      return b;
   endfunction

   always_comb begin
      req_all    = pending_q | bus.floorReq;
      above_mask = '0;
      below_mask = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         above_mask[i] = (3'(i) > cur_fl_q);
         below_mask[i] = (3'(i) < cur_fl_q);
      end

      // Floor reached when the running move completes; saturates at the ends.
      next_fl = cur_fl_q;
      if (dir_up_q) begin
         if (cur_fl_q != TOP_FLOOR) next_fl = cur_fl_q + 3'd1;
      end else begin
         if (cur_fl_q != 3'd0) next_fl = cur_fl_q - 3'd1;
      end

      cur_bit  = floor_bit(cur_fl_q);
      next_bit = floor_bit(next_fl);

      // IDLE decides on registered requests only.
      any_above  = |(pending_q & above_mask);
      any_below  = |(pending_q & below_mask);
      here_req   = |(pending_q & cur_bit);
      // On arrival a request arriving this very edge still makes the car stop.
      arrive_req = |(req_all & next_bit);
      // A press for the open floor keeps the door open.
      door_req   = |(bus.floorReq & cur_bit);
   end

   always_comb begin
      state_d  = state_q;
      cur_fl_d = cur_fl_q;
      dir_up_d = dir_up_q;
      timer_d  = timer_q;
      clr      = '0;

      case (state_q)
         ST_IDLE: begin
            if (here_req) begin
               state_d = ST_DOOR;
               clr     = cur_bit;
               timer_d = DOOR_LOAD;
            end else if (any_above && (dir_up_q || !any_below)) begin
               state_d  = ST_MOVE;
               dir_up_d = 1'b1;
               timer_d  = TRAVEL_LOAD;
            end else if (any_below) begin
               state_d  = ST_MOVE;
               dir_up_d = 1'b0;
               timer_d  = TRAVEL_LOAD;
            end
         end

         ST_MOVE: begin
            if (timer_q == '0) begin
               cur_fl_d = next_fl;
               if (arrive_req) begin
                  state_d = ST_DOOR;
                  clr     = next_bit;
                  timer_d = DOOR_LOAD;
               end else begin
                  timer_d = TRAVEL_LOAD;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_DOOR: begin
            // A fresh press wins over the dwell expiring on the same edge.
            if (door_req) begin
               clr     = cur_bit;
               timer_d = DOOR_LOAD;
            end else if (timer_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Clearing the served bit wins over a new press of that same floor.
      pending_d = req_all & ~clr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cur_fl_q  <= 3'd0;
         dir_up_q  <= 1'b1;
         timer_q   <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         cur_fl_q  <= cur_fl_d;
         dir_up_q  <= dir_up_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
      end
   end

   assign bus.currentFl = cur_fl_q;
   assign bus.moving    = (state_q == ST_MOVE);
   assign bus.doorOpen  = (state_q == ST_DOOR);
   assign bus.dirUp     = dir_up_q;
   assign bus.pending   = pending_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: directed scenarios plus random requests,
// checked every cycle against a floor/direction/request-list model.
module tb_elevator_controller;
   localparam int NF = 7;
   localparam int TC = 4;
   localparam int DC = 3;
   localparam int W  = 6 + NF;

   localparam int M_IDLE   = 0;
   localparam int M_TRAVEL = 1;
   localparam int M_DWELL  = 2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   elevator_controller_if #(.NUM_FLOORS(NF)) bus();

   elevator_controller #(
      .NUM_FLOORS(NF),
      .TRAVEL_CYCLES(TC),
      .DOOR_CYCLES(DC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   int           stop_log[$];

   // ---------------- reference model ----------------
   int m_fl;
   bit m_up;
   int m_mode;
   int m_left;
   bit m_pend[NF];

   task automatic model_reset();
      m_fl   = 0;
      m_up   = 1'b1;
      m_mode = M_IDLE;
      m_left = 0;
      for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
   endtask

   function automatic bit model_empty();
      for (int i = 0; i < NF; i++) if (m_pend[i]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock edge of the car, with r = requests sampled on that edge.
   task automatic model_step(input logic [NF-1:0] r);
      bit seen[NF];
      int above;
      int below;
      above = 0;
      below = 0;
      for (int i = 0; i < NF; i++) begin
         seen[i] = m_pend[i] | r[i];
         if (m_pend[i] && i > m_fl) above++;
         if (m_pend[i] && i < m_fl) below++;
      end
      case (m_mode)
         M_IDLE: begin
            if (m_pend[m_fl]) begin
               m_mode = M_DWELL;
               m_left = DC;
               seen[m_fl] = 1'b0;
            end else if (above > 0 && (m_up || below == 0)) begin
               m_up   = 1'b1;
               m_mode = M_TRAVEL;
               m_left = TC;
            end else if (below > 0) begin
               m_up   = 1'b0;
               m_mode = M_TRAVEL;
               m_left = TC;
            end
         end
         M_TRAVEL: begin
            m_left--;
            if (m_left == 0) begin
               if (m_up && m_fl < NF - 1) m_fl++;
               else if (!m_up && m_fl > 0) m_fl--;
               if (seen[m_fl]) begin
                  m_mode = M_DWELL;
                  m_left = DC;
                  seen[m_fl] = 1'b0;
               end else begin
                  m_left = TC;
               end
            end
         end
         default: begin
            if (r[m_fl]) begin
               seen[m_fl] = 1'b0;
               m_left = DC;
            end else begin
               m_left--;
               if (m_left == 0) m_mode = M_IDLE;
            end
         end
      endcase
      for (int i = 0; i < NF; i++) m_pend[i] = seen[i];
   endtask

   function automatic logic [W-1:0] model_view();
      logic [NF-1:0] p;
      for (int i = 0; i < NF; i++) p[i] = m_pend[i];
      return {3'(m_fl), (m_mode == M_TRAVEL), m_up, (m_mode == M_DWELL), p};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   logic prev_door = 1'b0;
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bus.currentFl, bus.moving, bus.dirUp, bus.doorOpen, bus.pending};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL cycle_out: got fl=%0d mv=%b up=%b door=%b pend=%b, want fl=%0d mv=%b up=%b door=%b pend=%b (t=%0t)",
                     a[W-1:W-3], a[W-4], a[W-5], a[W-6], a[NF-1:0],
                     e[W-1:W-3], e[W-4], e[W-5], e[W-6], e[NF-1:0], $time);
         end
      end
      if (bus.doorOpen && !prev_door) stop_log.push_back(int'(bus.currentFl));
      prev_door = bus.doorOpen;
   end

   // ---------------- driver tasks ----------------
   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle(input logic [NF-1:0] r);
      bus.floorReq = r;
      @(posedge clk);
      model_step(r);
      exp_q.push_back(model_view());
      @(negedge clk);
   endtask

   // Asserts reset between clock edges and checks it acts without an edge.
   task automatic do_reset(input int hold);
      bus.floorReq = '0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      exp_q.delete();
      model_reset();
      #1;
      chk("rst_fl",      int'(bus.currentFl), 0);
      chk("rst_moving",  int'(bus.moving),    0);
      chk("rst_door",    int'(bus.doorOpen),  0);
      chk("rst_pending", int'(bus.pending),   0);
      chk("rst_dir",     int'(bus.dirUp),     1);
      for (int i = 0; i < hold; i++) begin
         exp_q.push_back(model_view());
         @(negedge clk);
      end
      #2;
      reset = 1'b0;
   endtask

   task automatic run_until_idle(input string name, input int budget);
      int n;
      n = 0;
      while (!(m_mode == M_IDLE && model_empty()) && n < budget) begin
         cycle('0);
         n++;
      end
      chk(name, int'(m_mode == M_IDLE && model_empty()), 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int door_cnt;
      logic [NF-1:0] r;

      bus.floorReq = '0;
      model_reset();
      do_reset(2);

      // 1: single request for floor 3 from floor 0
      cycle(7'b0001000);
      for (int k = 1; k <= 16; k++) begin
         cycle('0);
         if (k == 1)  chk("t1_moving_e1", int'(bus.moving), 1);
         if (k == 4)  chk("t1_fl_e4", int'(bus.currentFl), 0);
         if (k == 5)  chk("t1_fl_e5", int'(bus.currentFl), 1);
         if (k == 9)  chk("t1_fl_e9", int'(bus.currentFl), 2);
         if (k == 12) chk("t1_door_e12", int'(bus.doorOpen), 0);
         if (k == 13) chk("t1_fl_e13", int'(bus.currentFl), 3);
         if (k == 13) chk("t1_door_e13", int'(bus.doorOpen), 1);
         if (k == 15) chk("t1_door_e15", int'(bus.doorOpen), 1);
         if (k == 16) chk("t1_door_e16", int'(bus.doorOpen), 0);
         if (k == 16) chk("t1_moving_e16", int'(bus.moving), 0);
         if (k == 16) chk("t1_pending_e16", int'(bus.pending), 0);
      end

      // 2: request the floor the idle car is already at
      do_reset(1);
      stop_log.delete();
      cycle(7'b0000001);
      cycle('0);
      chk("t2_door", int'(bus.doorOpen), 1);
      chk("t2_moving", int'(bus.moving), 0);
      chk("t2_pending", int'(bus.pending), 0);
      cycle('0);
      cycle('0);
      chk("t2_door_last", int'(bus.doorOpen), 1);
      cycle('0);
      chk("t2_door_closed", int'(bus.doorOpen), 0);
      chk("t2_stops", stop_log.size(), 1);

      // 3: requests behind and ahead while travelling up
      stop_log.delete();
      cycle(7'b1000000);
      n = 0;
      while (!(m_fl == 1 && m_mode == M_TRAVEL) && n < 20) begin
         cycle('0);
         n++;
      end
      chk("t3_reach_1", int'(m_fl == 1 && m_mode == M_TRAVEL), 1);
      cycle(7'b0010010);
      run_until_idle("t3_idle", 200);
      chk("t3_nstops", stop_log.size(), 3);
      if (stop_log.size() == 3) begin
         chk("t3_stop0", stop_log[0], 4);
         chk("t3_stop1", stop_log[1], 6);
         chk("t3_stop2", stop_log[2], 1);
      end
      chk("t3_dir_down", int'(bus.dirUp), 0);

      // 4: at floor 3 heading up, requests on both sides at once
      cycle(7'b0001000);
      run_until_idle("t4_go3", 100);
      chk("t4_at3", int'(bus.currentFl), 3);
      chk("t4_dir_up", int'(bus.dirUp), 1);
      stop_log.delete();
      cycle(7'b0100010);
      run_until_idle("t4_idle", 200);
      chk("t4_nstops", stop_log.size(), 2);
      if (stop_log.size() == 2) begin
         chk("t4_stop0", stop_log[0], 5);
         chk("t4_stop1", stop_log[1], 1);
      end

      // 6: repeated presses while the door is open at floor 5
      stop_log.delete();
      cycle(7'b0100000);
      n = 0;
      while (m_mode != M_DWELL && n < 60) begin
         cycle('0);
         n++;
      end
      chk("t6_reach_door", int'(m_mode == M_DWELL), 1);
      door_cnt = int'(bus.doorOpen);
      for (int i = 0; i < 4; i++) begin
         cycle(7'b0100000);
         door_cnt += int'(bus.doorOpen);
      end
      for (int i = 0; i < 10; i++) begin
         cycle('0);
         door_cnt += int'(bus.doorOpen);
      end
      chk("t6_door_cycles", door_cnt, 7);
      chk("t6_nstops", stop_log.size(), 1);

      // 5: reset while travelling between floors 2 and 3
      do_reset(1);
      cycle(7'b1000000);
      n = 0;
      while (!(m_fl == 2 && m_mode == M_TRAVEL) && n < 30) begin
         cycle('0);
         n++;
      end
      chk("t5_reach_2", int'(m_fl == 2 && m_mode == M_TRAVEL), 1);
      cycle('0);
      do_reset(2);
      stop_log.delete();
      cycle(7'b0000100);
      run_until_idle("t5_resume", 100);
      chk("t5_nstops", stop_log.size(), 1);
      if (stop_log.size() == 1) chk("t5_stop0", stop_log[0], 2);

      // random traffic with occasional reset
      for (int c = 0; c < 1500; c++) begin
         r = '0;
         if ($urandom_range(0, 5) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
         if ($urandom_range(0, 19) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
         if ($urandom_range(0, 499) == 0) do_reset(1);
         cycle(r);
      end
      run_until_idle("drain", 600);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
